// File: rtl/core_pkg.sv
// Shared core types: LSU state encoding, RV32I load/store funct3 codes, legality check.
// Pure declarations; no timing or flow control of its own.
package core_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal encoding for the direction, and natural alignment for the access size.
    function automatic logic access_legal(input logic       is_load,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic code_ok;
        logic align_ok;
        if (is_load)
            code_ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        else
            code_ok = funct3 inside {F3_B, F3_H, F3_W};
        case (funct3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~addr_lo[0];
            2'b10:   align_ok = (addr_lo == 2'b00);
            default: align_ok = 1'b0;
        endcase
        return code_ok & align_ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select plus sign/zero extension of the returned bus word.
// Purely combinational, zero latency, no flow control.
module lsu_load_align #(
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);
    import core_pkg::*;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            F3_H:    data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit driving a req/gnt/rvalid data port; store 2 stall cycles, load 3, +1 per gnt/rvalid wait.
// Backpressure: the pipeline is stalled from start until DONE; dmem_req_o is held stable until dmem_gnt_i.
module lsu #(
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  fault_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);
    import core_pkg::*;

    lsu_state_e            state;
    logic                  start;
    logic                  is_load;
    logic                  legal;
    logic                  load_q;
    logic [1:0]            addr_lo_q;
    logic [2:0]            funct3_q;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] load_ext;

    // A simultaneous read+write request is resolved as a load.
    assign start   = valid_i & (mem_read_i | mem_write_i);
    assign is_load = mem_read_i;
    assign legal   = access_legal(is_load, funct3_i, addr_i[1:0]);

    assign stall_o = ((state == IDLE) & start & legal) | (state == REQ) | (state == WAIT);
    assign fault_o = (state == IDLE) & start & ~legal;
    assign done_o  = (state == DONE);

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = '0;
        if (!is_load) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_next    = 4'b0001 << addr_i[1:0];
                    wdata_next = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    be_next    = 4'b0011 << addr_i[1:0];
                    wdata_next = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = wdata_i;
                end
            endcase
        end
    end

    lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .word    (dmem_rdata_i),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .data    (load_ext)
    );

    // Bus outputs are loaded on entry to REQ and cleared on grant, so they are nonzero only in REQ.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= '0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            rdata_o      <= '0;
            load_q       <= 1'b0;
            addr_lo_q    <= '0;
            funct3_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && legal) begin
                        state        <= REQ;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= ~is_load;
                        dmem_be_o    <= be_next;
                        dmem_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                        dmem_wdata_o <= wdata_next;
                        load_q       <= is_load;
                        addr_lo_q    <= addr_i[1:0];
                        funct3_q     <= funct3_i;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        state        <= load_q ? WAIT : DONE;
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        dmem_be_o    <= '0;
                        dmem_addr_o  <= '0;
                        dmem_wdata_o <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        rdata_o <= load_ext;
                        state   <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: hand-computed bus formatting, load extension, latency, faults and reset recovery.
module tb_lsu;
    import core_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, fault, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [3:0]  dmem_be;
    logic [31:0] rdata, dmem_addr, dmem_wdata, dmem_rdata;

    logic [31:0] ref_word, ref_data;
    logic [1:0]  ref_lo;
    logic [2:0]  ref_f3;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] mem_word;
    int          grants, stalls, dones;
    logic        fin, unstable, cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    lsu dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .done_o(done),
        .rdata_o(rdata), .fault_o(fault), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .dmem_be_o(dmem_be), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata)
    );

    lsu_load_align ref_model (.word(ref_word), .addr_lo(ref_lo), .funct3(ref_f3), .data(ref_data));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Called at posedge+1 of the start cycle; returns at posedge+2 of the DONE cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int gnt_wait, input int rv_wait);
        int  reqcnt = 0;
        int  since  = 0;
        logic gnt_given = 1'b0;
        valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        stalls = 0; dones = 0; fin = 1'b0; unstable = 1'b0;
        cap_be = '0; cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            #1;
            if (stall) stalls++;
            if (done) begin
                dones++;
                fin = 1'b1;
            end else begin
                dmem_gnt = 1'b0;
                dmem_rvalid = 1'b0;
                if (gnt_given) since++;
                if (dmem_req) begin
                    if (reqcnt == 0) begin
                        cap_be = dmem_be; cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_we = dmem_we;
                    end else if (cap_be !== dmem_be || cap_addr !== dmem_addr ||
                                 cap_wdata !== dmem_wdata || cap_we !== dmem_we) begin
                        unstable = 1'b1;
                    end
                    if (reqcnt == gnt_wait) begin
                        dmem_gnt = 1'b1;
                        gnt_given = 1'b1;
                        grants++;
                        if (dmem_we)
                            for (int b = 0; b < 4; b++)
                                if (dmem_be[b]) mem_word[8*b +: 8] = dmem_wdata[8*b +: 8];
                    end
                    reqcnt++;
                end
                if (gnt_given && since == 1 + rv_wait) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata = mem_word;
                end
                @(posedge clk); #1;
            end
        end
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        chk("no_timeout", {31'b0, fin}, 32'd1);
    endtask

    task automatic next_idle();
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        mem_word = '0; grants = 0;
        ref_word = '0; ref_lo = '0; ref_f3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SB 0xA5 to 0x1003, immediate grant
        do_access(1'b0, 1'b1, F3_B, 32'h0000_1003, 32'h0000_00A5, 0, 0);
        chk("sb_be", {28'b0, cap_be}, 32'h8);
        chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", cap_addr, 32'h0000_1000);
        chk("sb_we", {31'b0, cap_we}, 32'd1);
        chk("sb_stalls", stalls, 2);
        chk("sb_done_req", {31'b0, dmem_req}, 32'd0);
        next_idle();
        #1;
        chk("sb_done_pulse", {31'b0, done}, 32'd0);

        // LB from 0x2001, grant after 2 wait cycles, rvalid right after grant
        mem_word = 32'h0000_80FF;
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, F3_B, 32'h0000_2001, 32'h0, 2, 0);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        chk("lb_stalls", stalls, 5);
        chk("lb_addr", cap_addr, 32'h0000_2000);
        chk("lb_be", {28'b0, cap_be}, 32'hF);
        chk("lb_we", {31'b0, cap_we}, 32'd0);
        chk("lb_stable", {31'b0, unstable}, 32'd0);
        next_idle();
        #1;
        chk("lb_hold", rdata, 32'hFFFF_FF80);

        do_access(1'b1, 1'b0, F3_HU, 32'h0000_2002, 32'h0, 0, 0);
        chk("lhu_hi", rdata, 32'h0000_0000);
        chk("lhu_hi_stalls", stalls, 3);
        next_idle();
        do_access(1'b1, 1'b0, F3_HU, 32'h0000_2000, 32'h0, 0, 0);
        chk("lhu_lo", rdata, 32'h0000_80FF);
        next_idle();

        // LH signed on upper half, one extra rvalid wait
        mem_word = 32'h8000_1234;
        ref_word = mem_word; ref_lo = 2'd2; ref_f3 = F3_H;
        do_access(1'b1, 1'b0, F3_H, 32'h0000_2002, 32'h0, 0, 1);
        chk("lh_rdata", rdata, 32'hFFFF_8000);
        chk("lh_vs_model", rdata, ref_data);
        chk("lh_stalls", stalls, 4);
        next_idle();

        // Misaligned and illegal-funct3 accesses
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h0000_3002;
        #1;
        chk("lw_mis_fault", {31'b0, fault}, 32'd1);
        chk("lw_mis_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("lw_mis_req", {31'b0, dmem_req}, 32'd0);
        chk("lw_mis_state", 32'(dut.state), 32'(IDLE));
        mem_read = 1'b0; mem_write = 1'b1; funct3 = F3_H; addr = 32'h0000_3001;
        #1;
        chk("sh_mis_fault", {31'b0, fault}, 32'd1);
        chk("sh_mis_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("sh_mis_req", {31'b0, dmem_req}, 32'd0);
        chk("sh_mis_state", 32'(dut.state), 32'(IDLE));
        funct3 = F3_BU; addr = 32'h0000_3000;
        #1;
        chk("store_f3_fault", {31'b0, fault}, 32'd1);
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011;
        #1;
        chk("load_f3_fault", {31'b0, fault}, 32'd1);
        valid = 1'b0;
        #1;
        chk("no_valid_fault", {31'b0, fault}, 32'd0);
        @(posedge clk); #1;
        chk("illegal_state", 32'(dut.state), 32'(IDLE));

        // Reset while a load is waiting for rvalid
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h0000_5000;
        @(posedge clk); #1;
        chk("rw_req", {31'b0, dmem_req}, 32'd1);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        chk("rw_in_wait", 32'(dut.state), 32'(WAIT));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; valid = 1'b0; mem_read = 1'b0;
        #1;
        chk("rw_state", 32'(dut.state), 32'(IDLE));
        chk("rw_req_low", {31'b0, dmem_req}, 32'd0);
        chk("rw_stall", {31'b0, stall}, 32'd0);
        chk("rw_rdata_clr", rdata, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        #1;
        chk("rw_late_done", {31'b0, done}, 32'd0);
        chk("rw_late_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        chk("rw_late_done2", {31'b0, done}, 32'd0);

        // SW then LW back-to-back through the memory model
        mem_word = '0; grants = 0;
        do_access(1'b0, 1'b1, F3_W, 32'h0000_4000, 32'hDEAD_BEEF, 0, 0);
        chk("sw_dones", dones, 1);
        chk("sw_stalls", stalls, 2);
        chk("sw_be", {28'b0, cap_be}, 32'hF);
        chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, F3_W, 32'h0000_4000, 32'h0, 1, 1);
        chk("lw_dones", dones, 1);
        chk("lw_stalls", stalls, 5);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);
        chk("b2b_grants", grants, 2);
        chk("b2b_mem", mem_word, 32'hDEAD_BEEF);
        next_idle();
        #1;
        chk("b2b_done_pulse", {31'b0, done}, 32'd0);
        chk("b2b_req_idle", {31'b0, dmem_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
